// File: rtl/qam_demapper.sv
// ---------------------------------------------------------------------------
// qam_demapper
//
// Hard-decision QAM demapper and byte packer. It sits directly behind the
// equalizer. Gray-coded bits are decided from the I/Q data subcarriers and
// packed MSB-first into bytes. The last byte of every OFDM symbol is tagged.
// Bytes leave through a first-word-fall-through FIFO with valid/ready.
//
// Pipeline:
//   t   : decision (modulation latch, per-axis slicing) -> dec_*_q
//   t+1 : symbol flush + accumulator + pending byte     -> up to 2 FIFO writes
//   t+2 : byte visible at obyte/ovalid
//
// Ports:
//   clk, rst         clock; synchronous active-high reset
//   ival             subcarrier valid
//   isop             first subcarrier of an OFDM symbol (qualified by ival)
//   ieof             end-of-burst pulse; flushes the symbol received so far
//   index[1:0]       subcarrier type, 2'b01 = data, all other values ignored
//   index_M[2:0]     0 BPSK, 1 QPSK, 2 16QAM, 3 64QAM, 4..7 reserved (no bits)
//   isub_i/isub_q    equalized I/Q, signed, W bits
//   obyte[7:0]       packed byte, first received bit in bit 7
//   olast            obyte closes its OFDM symbol
//   ovalid / oready  output handshake, transfer when both are high
//   ovf              sticky FIFO overflow, cleared only by rst
//
// Symbol boundaries are a data isop or ieof. Both close the bits that were
// received before the current cycle. A data subcarrier that arrives in the
// same cycle as ieof therefore opens the next accumulation instead of
// joining the flushed symbol. This keeps a boundary at two FIFO writes at
// most, and the FIFO provides a dual write port for those two writes.
// ---------------------------------------------------------------------------
module qam_demapper #(
   parameter int W          = 12,
   parameter int STEP       = 256,
   parameter int FIFO_DEPTH = 64
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         ival,
   input  logic         isop,
   input  logic         ieof,
   input  logic [1:0]   index,
   input  logic [2:0]   index_M,
   input  logic [W-1:0] isub_i,
   input  logic [W-1:0] isub_q,
   output logic [7:0]   obyte,
   output logic         olast,
   output logic         ovalid,
   input  logic         oready,
   output logic         ovf
);

   localparam int AW = $clog2(FIFO_DEPTH);

   // Magnitude thresholds. They are W+1 bits wide to match the magnitude.
   localparam logic [W:0] LVL2 = (W+1)'(2 * STEP);
   localparam logic [W:0] LVL4 = (W+1)'(4 * STEP);
   localparam logic [W:0] LVL6 = (W+1)'(6 * STEP);

   typedef enum logic [2:0] {
      MOD_BPSK  = 3'd0,
      MOD_QPSK  = 3'd1,
      MOD_16QAM = 3'd2,
      MOD_64QAM = 3'd3,
      MOD_RSV4  = 3'd4,
      MOD_RSV5  = 3'd5,
      MOD_RSV6  = 3'd6,
      MOD_RSV7  = 3'd7
   } mod_e;

   typedef struct packed {
      logic       last;
      logic [7:0] data;
   } entry_t;

   // Per-axis decision, returned as {sign, b1_16qam, b1_64qam, b2_64qam}.
   // The magnitude is taken in W+1 bits, so -2^(W-1) does not wrap.
   function automatic logic [3:0] axis_dec(input logic [W-1:0] x);
      logic [W:0] ext;
      logic [W:0] mag;
      ext = {x[W-1], x};
      mag = x[W-1] ? (~ext + 1'b1) : ext;
      axis_dec = {~x[W-1],
                  (mag < LVL2),
                  (mag < LVL4),
                  (mag >= LVL2) && (mag < LVL6)};
   endfunction

   // ------------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------------
   mod_e            mod_q,       mod_d;
   logic [5:0]      dec_bits_q,  dec_bits_d;   // right-aligned, first bit highest
   logic [2:0]      dec_n_q,     dec_n_d;      // 0..6 bits carried
   logic            dec_flush_q, dec_flush_d;
   logic [15:0]     acc_q,       acc_d;        // right-aligned bit accumulator
   logic [3:0]      cnt_q,       cnt_d;        // 0..7 between cycles
   logic [7:0]      pend_q,      pend_d;
   logic            pend_vld_q,  pend_vld_d;
   logic [AW-1:0]   wptr_q,      wptr_d;
   logic [AW-1:0]   rptr_q,      rptr_d;
   logic [AW:0]     count_q,     count_d;
   logic            ovf_q,       ovf_d;

   entry_t          fifo_mem [FIFO_DEPTH];

   // ------------------------------------------------------------------------
   // Decision stage
   // ------------------------------------------------------------------------
   logic       sop_fire;
   logic       data_sc;
   logic [3:0] dec_i;
   logic [3:0] dec_q;
   logic [5:0] sc_bits;
   logic [2:0] sc_n;

   // NOTE: every signal written here receives a default first. An incomplete
   // branch therefore cannot infer a latch.
   always_comb begin
      sop_fire = ival & isop;
      data_sc  = ival & (index == 2'b01);
      // The isop subcarrier already uses its own index_M. Later changes in
      // the same symbol are ignored.
      mod_d    = sop_fire ? mod_e'(index_M) : mod_q;
      dec_i    = axis_dec(isub_i);
      dec_q    = axis_dec(isub_q);
      sc_bits  = '0;
      sc_n     = '0;

      case (mod_d)
         MOD_BPSK: begin
            sc_bits = {5'b0, dec_i[3]};
            sc_n    = 3'd1;
         end
         MOD_QPSK: begin
            sc_bits = {4'b0, dec_i[3], dec_q[3]};
            sc_n    = 3'd2;
         end
         MOD_16QAM: begin
            sc_bits = {2'b0, dec_i[3], dec_i[2], dec_q[3], dec_q[2]};
            sc_n    = 3'd4;
         end
         MOD_64QAM: begin
            sc_bits = {dec_i[3], dec_i[1], dec_i[0], dec_q[3], dec_q[1], dec_q[0]};
            sc_n    = 3'd6;
         end
         default: begin
            // Reserved modulation: the whole symbol is skipped.
            sc_bits = '0;
            sc_n    = '0;
         end
      endcase

      dec_bits_d  = data_sc ? sc_bits : '0;
      dec_n_d     = data_sc ? sc_n    : '0;
      dec_flush_d = (sop_fire & data_sc) | ieof;
   end

   // ------------------------------------------------------------------------
   // Flush, accumulator and pending byte
   // ------------------------------------------------------------------------
   logic [15:0] acc_base;
   logic [3:0]  cnt_base;
   logic [15:0] acc_sum;
   logic [3:0]  cnt_sum;
   logic [15:0] pad_wide;
   logic [15:0] done_wide;
   logic        wr0_en;
   logic        wr1_en;
   entry_t      wr0_data;
   entry_t      wr1_data;

   always_comb begin
      acc_base   = acc_q;
      cnt_base   = cnt_q;
      pend_d     = pend_q;
      pend_vld_d = pend_vld_q;
      wr0_en     = 1'b0;
      wr1_en     = 1'b0;
      wr0_data   = '0;
      wr1_data   = '0;
      // Partial bits are moved to the top of a byte, and the low bits are
      // zero-padded. Bits above the count are stale and fall off the slice.
      pad_wide   = acc_q << (4'd8 - cnt_q);

      // Close the previous symbol before this cycle's bits enter.
      if (dec_flush_q) begin
         if (pend_vld_q && (cnt_q != '0)) begin
            wr0_en   = 1'b1;
            wr0_data = '{last: 1'b0, data: pend_q};
            wr1_en   = 1'b1;
            wr1_data = '{last: 1'b1, data: pad_wide[7:0]};
         end else if (pend_vld_q) begin
            wr0_en   = 1'b1;
            wr0_data = '{last: 1'b1, data: pend_q};
         end else if (cnt_q != '0) begin
            wr0_en   = 1'b1;
            wr0_data = '{last: 1'b1, data: pad_wide[7:0]};
         end
         acc_base   = '0;
         cnt_base   = '0;
         pend_vld_d = 1'b0;
      end

      acc_sum   = (acc_base << dec_n_q) | {10'b0, dec_bits_q};
      cnt_sum   = cnt_base + {1'b0, dec_n_q};
      done_wide = acc_sum >> (cnt_sum - 4'd8);

      // After a flush the count is at most 6, so no byte completes and the
      // write port is free. In that case at most one write occurs here.
      if (cnt_sum >= 4'd8) begin
         if (pend_vld_d) begin
            wr0_en   = 1'b1;
            wr0_data = '{last: 1'b0, data: pend_d};
         end
         pend_d     = done_wide[7:0];
         pend_vld_d = 1'b1;
         cnt_sum    = cnt_sum - 4'd8;
      end

      acc_d = acc_sum;
      cnt_d = cnt_sum;
   end

   // ------------------------------------------------------------------------
   // Output FIFO (first-word fall-through, two write ports)
   // ------------------------------------------------------------------------
   logic          fifo_nempty;
   logic          rd_fire;
   logic [AW+1:0] free_slots;
   logic [1:0]    n_req;
   logic [1:0]    n_acc;
   logic          we0;
   logic          we1;
   entry_t        head;

   always_comb begin
      fifo_nempty = (count_q != '0);
      rd_fire     = fifo_nempty & oready;
      // A read in the same cycle frees a slot. A full FIFO can therefore
      // still accept a write when it is also read.
      free_slots  = (AW+2)'(FIFO_DEPTH) - (AW+2)'(count_q) + (AW+2)'(rd_fire);
      n_req       = 2'(wr0_en) + 2'(wr1_en);
      if ((AW+2)'(n_req) <= free_slots) begin
         n_acc = n_req;
      end else begin
         n_acc = free_slots[1:0];
      end
      we0     = (n_acc != 2'd0);
      we1     = (n_acc == 2'd2);
      ovf_d   = ovf_q | (n_acc != n_req);
      count_d = count_q - (AW+1)'(rd_fire) + (AW+1)'(n_acc);
      wptr_d  = wptr_q + AW'(n_acc);
      rptr_d  = rptr_q + AW'(rd_fire);

      head    = fifo_mem[rptr_q];
      ovalid  = fifo_nempty;
      obyte   = fifo_nempty ? head.data : '0;
      olast   = fifo_nempty ? head.last : 1'b0;
      ovf     = ovf_q;
   end

   // ------------------------------------------------------------------------
   // Registers
   // ------------------------------------------------------------------------
   // NOTE: non-blocking assignments make every flop sample the values from
   // before the clock edge, regardless of the statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         mod_q       <= MOD_BPSK;
         dec_bits_q  <= '0;
         dec_n_q     <= '0;
         dec_flush_q <= 1'b0;
         acc_q       <= '0;
         cnt_q       <= '0;
         pend_q      <= '0;
         pend_vld_q  <= 1'b0;
         wptr_q      <= '0;
         rptr_q      <= '0;
         count_q     <= '0;
         ovf_q       <= 1'b0;
      end else begin
         mod_q       <= mod_d;
         dec_bits_q  <= dec_bits_d;
         dec_n_q     <= dec_n_d;
         dec_flush_q <= dec_flush_d;
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
         pend_q      <= pend_d;
         pend_vld_q  <= pend_vld_d;
         wptr_q      <= wptr_d;
         rptr_q      <= rptr_d;
         count_q     <= count_d;
         ovf_q       <= ovf_d;
      end
   end

   // NOTE: the storage array has no reset. A reset of count_q empties the
   // FIFO, and the outputs are gated on a non-zero count. As a result, stale
   // entries are never visible.
   always_ff @(posedge clk) begin
      if (we0) fifo_mem[wptr_q] <= wr0_data;
      if (we1) fifo_mem[wptr_q + AW'(1)] <= wr1_data;
   end

endmodule

// File: tb/tb_qam_demapper.sv
module tb_qam_demapper;

   localparam int W     = 12;
   localparam int STEP  = 256;
   localparam int DEPTH = 64;

   logic         clk;
   logic         rst;
   logic         ival;
   logic         isop;
   logic         ieof;
   logic [1:0]   index;
   logic [2:0]   index_M;
   logic [W-1:0] isub_i;
   logic [W-1:0] isub_q;
   logic [7:0]   obyte;
   logic         olast;
   logic         ovalid;
   logic         oready;
   logic         ovf;

   int total = 0;
   int bad   = 0;

   qam_demapper #(.W(W), .STEP(STEP), .FIFO_DEPTH(DEPTH)) dut (
      .clk     (clk),
      .rst     (rst),
      .ival    (ival),
      .isop    (isop),
      .ieof    (ieof),
      .index   (index),
      .index_M (index_M),
      .isub_i  (isub_i),
      .isub_q  (isub_q),
      .obyte   (obyte),
      .olast   (olast),
      .ovalid  (ovalid),
      .oready  (oready),
      .ovf     (ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      total++;
      assert (obs === exp_v) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
      end
   endtask

   // One subcarrier, driven at the falling edge and held for one cycle.
   task automatic sc(input logic sop, input logic [1:0] idx, input logic [2:0] m,
                     input int i_v, input int q_v);
      @(negedge clk);
      ival    = 1'b1;
      isop    = sop;
      ieof    = 1'b0;
      index   = idx;
      index_M = m;
      isub_i  = W'(i_v);
      isub_q  = W'(q_v);
   endtask

   task automatic eof();
      @(negedge clk);
      ival = 1'b0;
      isop = 1'b0;
      ieof = 1'b1;
      @(negedge clk);
      ieof = 1'b0;
   endtask

   task automatic wait_cycles(input int n);
      @(negedge clk);
      ival = 1'b0;
      isop = 1'b0;
      ieof = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   // Waits a bounded time for a byte, checks it, and accepts it for one cycle.
   task automatic pop(input string tag, input logic [7:0] eb, input logic el);
      int n;
      n = 0;
      @(negedge clk);
      while (!ovalid && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_valid"}, 32'(ovalid), 32'd1);
      chk({tag, "_byte"},  32'(obyte),  32'(eb));
      chk({tag, "_last"},  32'(olast),  32'(el));
      oready = 1'b1;
      @(negedge clk);
      oready = 1'b0;
   endtask

   // QPSK encoder: two bits per subcarrier, MSB first, sign carries the bit.
   task automatic send_qpsk_byte(input logic [7:0] b, input logic first);
      for (int j = 0; j < 4; j++) begin
         sc(first && (j == 0), 2'b01, 3'd1,
            b[7-2*j] ? STEP : -STEP,
            b[6-2*j] ? STEP : -STEP);
      end
   endtask

   function automatic logic [7:0] t5_val(input int k);
      return 8'((k * 29 + 7) & 255);
   endfunction

   logic [11:0] t4_bits;
   logic [7:0]  t6_bpsk;

   initial begin
      rst = 1'b1; ival = 1'b0; isop = 1'b0; ieof = 1'b0; index = 2'b00;
      index_M = 3'd0; isub_i = '0; isub_q = '0; oready = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("reset_ovalid", 32'(ovalid), 32'd0);
      chk("reset_obyte",  32'(obyte),  32'd0);
      chk("reset_olast",  32'(olast),  32'd0);
      chk("reset_ovf",    32'(ovf),    32'd0);

      // QPSK symbol: 10 01 11 00. The symbol is closed by the next data isop.
      sc(1'b1, 2'b01, 3'd1,  300, -300);
      sc(1'b0, 2'b01, 3'd1,   -5,    5);
      sc(1'b0, 2'b01, 3'd1,    0,    0);
      sc(1'b0, 2'b01, 3'd1, -900, -900);
      // 16QAM symbol: (+3,-1) -> 10 01, (+1,-3) -> 11 00, (+1,+1) -> 11 11, then ieof.
      sc(1'b1, 2'b01, 3'd2,  3*STEP,   -STEP);
      sc(1'b0, 2'b01, 3'd2,    STEP, -3*STEP);
      sc(1'b0, 2'b01, 3'd2,    STEP,    STEP);
      eof();
      pop("qpsk",      8'h9C, 1'b1);
      pop("qam16_b0",  8'h9C, 1'b0);
      pop("qam16_pad", 8'hF0, 1'b1);

      // 64QAM threshold edges on I with Q=0 (Q bits 110).
      // I bits: 110 111 101 101 100 000.
      sc(1'b1, 2'b01, 3'd3, 2*STEP-1, 0);
      sc(1'b0, 2'b01, 3'd3, 2*STEP,   0);
      sc(1'b0, 2'b01, 3'd3, 4*STEP,   0);
      sc(1'b0, 2'b01, 3'd3, 6*STEP-1, 0);
      sc(1'b0, 2'b01, 3'd3, 6*STEP,   0);
      sc(1'b0, 2'b01, 3'd3, -2048,    0);
      eof();
      pop("qam64_b0",  8'hDB, 1'b0);
      pop("qam64_b1",  8'hEB, 1'b0);
      pop("qam64_b2",  8'hAE, 1'b0);
      pop("qam64_b3",  8'h98, 1'b0);
      pop("qam64_pad", 8'h60, 1'b1);

      // BPSK: 12 data bits, with pilots interleaved. index_M goes to 3 halfway.
      t4_bits = 12'b1011_0010_1110;
      for (int k = 0; k < 12; k++) begin
         sc(k == 0, 2'b01, (k < 6) ? 3'd0 : 3'd3,
            t4_bits[11-k] ? STEP : -STEP, -3*STEP);
         if (k % 2 == 1) sc(1'b0, 2'b10, (k < 6) ? 3'd0 : 3'd3, -7*STEP, 7*STEP);
      end
      eof();
      pop("bpsk_b0",  8'hB2, 1'b0);
      pop("bpsk_pad", 8'hE0, 1'b1);

      // A symbol with a reserved modulation produces nothing.
      sc(1'b1, 2'b01, 3'd5, STEP, STEP);
      sc(1'b0, 2'b01, 3'd5, STEP, STEP);
      sc(1'b0, 2'b01, 3'd1, STEP, STEP);
      eof();
      wait_cycles(6);
      chk("reserved_empty", 32'(ovalid), 32'd0);
      chk("pre_ovf_clear",  32'(ovf),    32'd0);

      // Overflow: DEPTH+3 bytes arrive while oready is low.
      for (int k = 0; k < DEPTH + 3; k++) send_qpsk_byte(t5_val(k), k == 0);
      eof();
      wait_cycles(4);
      chk("ovf_set",  32'(ovf),   32'd1);
      chk("ovf_hold", 32'(obyte), 32'(t5_val(0)));
      for (int k = 0; k < DEPTH; k++) pop($sformatf("ovf_rd%0d", k), t5_val(k), 1'b0);
      wait_cycles(2);
      chk("ovf_drained", 32'(ovalid), 32'd0);
      chk("ovf_sticky",  32'(ovf),    32'd1);

      // Reset mid-symbol: one byte is stored and 5 BPSK bits are in flight.
      send_qpsk_byte(8'h3C, 1'b1);
      eof();
      for (int k = 0; k < 5; k++) sc(k == 0, 2'b01, 3'd0, STEP, STEP);
      @(negedge clk);
      ival = 1'b0;
      rst  = 1'b1;
      @(negedge clk);
      rst  = 1'b0;
      chk("rst_ovalid", 32'(ovalid), 32'd0);
      chk("rst_obyte",  32'(obyte),  32'd0);
      chk("rst_olast",  32'(olast),  32'd0);
      chk("rst_ovf",    32'(ovf),    32'd0);
      // There is no isop here, so the reset modulation (BPSK) applies.
      t6_bpsk = 8'hC5;
      for (int k = 0; k < 8; k++) sc(1'b0, 2'b01, 3'd3, t6_bpsk[7-k] ? STEP : -STEP, -STEP);
      eof();
      pop("rst_bpsk", 8'hC5, 1'b1);
      send_qpsk_byte(8'h5A, 1'b1);
      eof();
      pop("rst_qpsk", 8'h5A, 1'b1);
      wait_cycles(3);
      chk("rst_tail_empty", 32'(ovalid), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
